// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, issues credit-limited word fetches and
// buffers returned instructions for ID, with redirect flush and stale-response drop.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready,
   output logic        fetch_fault
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_FAULT
   } state_t;

   state_t state, state_nx;

   logic [31:0]      pc;
   logic [31:0]      rsp_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] fifo_count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [31:0]      buf_instr [BUF_DEPTH];
   logic [31:0]      buf_pc    [BUF_DEPTH];

   logic             redirect_misaligned;
   logic             pop;
   logic             push;
   logic             req_fire;
   logic             rsp_fire;
   logic             credit_ok;
   logic [CNT_W:0]   credit_used;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign redirect_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
   assign if_valid            = (fifo_count != '0) & !redirect_valid;
   assign pop                 = if_valid & id_ready;
   assign req_fire            = imem_req_valid & imem_req_ready;
   // Responses with nothing outstanding are spurious (e.g. left over from before reset).
   assign rsp_fire            = imem_rsp_valid & (outstanding != '0);
   assign push                = rsp_fire & (drop_cnt == '0) & !redirect_valid & (state == S_RUN);

   // Entries in flight plus entries buffered never exceed the FIFO depth.
   assign credit_used = (CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop);
   assign credit_ok   = credit_used < (CNT_W+1)'(BUF_DEPTH);

   assign imem_req_addr = pc;
   assign if_instr      = buf_instr[rd_ptr];
   assign if_pc         = buf_pc[rd_ptr];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_BOOT;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_BOOT:  state_nx = redirect_misaligned ? S_FAULT : S_RUN;
         S_RUN:   if (redirect_misaligned) state_nx = S_FAULT;
         S_FAULT: if (redirect_valid && !redirect_misaligned) state_nx = S_RUN;
         default: state_nx = S_BOOT;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      imem_req_valid = 1'b0;
      fetch_fault    = 1'b0;
      case (state)
         S_RUN:   imem_req_valid = !redirect_valid & credit_ok;
         S_FAULT: fetch_fault    = 1'b1;
         default: ;
      endcase
   end

   // PC, credit counters and instruction FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            buf_instr[i] <= '0;
            buf_pc[i]    <= '0;
         end
      end else begin
         outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
         if (redirect_valid) begin
            // Everything still in flight belongs to the old path.
            pc         <= redirect_pc;
            rsp_pc     <= redirect_pc;
            drop_cnt   <= outstanding - CNT_W'(rsp_fire);
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
         end else begin
            if (req_fire) pc <= pc + 32'd4;
            if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
            if (push) begin
               buf_instr[wr_ptr] <= imem_rsp_data;
               buf_pc[wr_ptr]    <= rsp_pc;
               wr_ptr            <= ptr_inc(wr_ptr);
               rsp_pc            <= rsp_pc + 32'd4;
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory model, expected PC/instr stream per
// path, and an independent monitor checking every delivery to ID.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int unsigned BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready = 1'b1;
   logic        fetch_fault;

   fetch_sequencer #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   mreq_t       mem_q[$];
   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          n_pops = 0;
   int unsigned lat_min = 1, lat_max = 1, id_pct = 100, req_pct = 100;
   logic [31:0] model_pc = RESET_PC;
   logic        model_live = 1'b1;
   logic        exp_fault = 1'b0;
   logic        prev_redir = 1'b0;
   logic [31:0] prev_rpc = '0;
   logic        inject_late = 1'b0;
   logic        meas = 1'b0;
   int          mark = 0, first_req = -1, first_if = -1, n_valid = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] hold_pc = '0, hold_instr = '0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk32(name, 32'(act), 32'(exp));
   endtask

   // One cycle of stimulus, starting and ending at a falling edge.
   task automatic step(input logic redir, input logic [31:0] rpc);
      int d;
      if (prev_redir) exp_fault = (prev_rpc[1:0] != 2'b00);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (inject_late) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hDEAD_BEEF;
         inject_late    = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_fn(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
      imem_req_ready = ($urandom_range(0, 99) < req_pct);
      id_ready       = ($urandom_range(0, 99) < id_pct);
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (redir) begin
         exp_q.delete();
         model_pc   = rpc;
         model_live = (rpc[1:0] == 2'b00);
      end
      while (model_live && exp_q.size() < 4) begin
         exp_q.push_back('{model_pc, mem_fn(model_pc)});
         model_pc = model_pc + 32'd4;
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         d = cyc + int'($urandom_range(lat_min, lat_max));
         if (d <= last_due) d = last_due + 1;
         mem_q.push_back('{imem_req_addr, d});
         last_due = d;
      end
      if (meas) begin
         if (first_req < 0 && imem_req_valid) first_req = cyc - mark;
         if (first_if < 0 && if_valid) first_if = cyc - mark;
         if (if_valid) n_valid++;
      end
      prev_redir = redir;
      prev_rpc   = rpc;
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   task automatic do_reset(input logic late);
      reset          = 1'b1;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      mem_q.delete();
      exp_q.delete();
      #2;
      chk1("rst_if_valid", if_valid, 1'b0);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_fault", fetch_fault, 1'b0);
      chk32("rst_req_addr", imem_req_addr, RESET_PC);
      chk32("rst_if_instr", if_instr, 32'h0);
      chk32("rst_if_pc", if_pc, 32'h0);
      @(negedge clk); cyc++;
      @(negedge clk); cyc++;
      model_pc    = RESET_PC;
      model_live  = 1'b1;
      exp_fault   = 1'b0;
      prev_redir  = 1'b0;
      last_due    = cyc;
      inject_late = late;
      reset       = 1'b0;
   endtask

   task automatic start_meas();
      meas = 1'b1; mark = cyc; first_req = -1; first_if = -1; n_valid = 0;
   endtask

   // Monitor: compares every ID handshake against the scoreboard, plus invariants.
   always begin
      @(negedge clk);
      #2;
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         chk1("fault_flag", fetch_fault, exp_fault);
         chk1("inflight_bound", mem_q.size() <= BUF_DEPTH, 1'b1);
         if (exp_fault) begin
            chk1("fault_no_req", imem_req_valid, 1'b0);
            chk1("fault_no_if", if_valid, 1'b0);
         end
         if (redirect_valid) begin
            chk1("redir_if_valid", if_valid, 1'b0);
            chk1("redir_req_valid", imem_req_valid, 1'b0);
         end
         if (imem_req_valid) chk32("req_align", 32'(imem_req_addr[1:0]), 32'h0);
         if (prev_hold && if_valid) begin
            chk32("hold_pc", if_pc, hold_pc);
            chk32("hold_instr", if_instr, hold_instr);
         end
         if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pop: got pc %h, want no delivery (cycle %0d)", if_pc, cyc);
            end else begin
               chk32("if_pc", if_pc, exp_q[0].pc);
               chk32("if_instr", if_instr, exp_q[0].instr);
               void'(exp_q.pop_front());
            end
            n_pops++;
         end
         prev_hold  = if_valid && !id_ready;
         hold_pc    = if_pc;
         hold_instr = if_instr;
      end
   end

   initial begin
      int          n, p0;
      logic        redir;
      logic [31:0] rpc;
      @(negedge clk);

      // Boot: first request one cycle after BOOT, first instruction three cycles after.
      do_reset(1'b0);
      start_meas();
      idle(12);
      meas = 1'b0;
      chk32("boot_first_req", 32'(first_req), 32'd1);
      chk32("boot_first_if", 32'(first_if), 32'd3);
      chk32("boot_throughput", 32'(n_valid), 32'd9);

      // ID stall then release.
      p0 = n_pops;
      id_pct = 0;   idle(5);
      id_pct = 100; idle(8);
      chk1("stall_progress", n_pops - p0 >= 6, 1'b1);

      // Slow memory: redirect with two fetches in flight.
      lat_min = 3; lat_max = 3;
      n = 0;
      while (mem_q.size() < 2 && n < 20) begin idle(1); n++; end
      chk1("t3_two_inflight", mem_q.size() == 2, 1'b1);
      p0 = n_pops;
      step(1'b1, 32'h0000_0100);
      idle(15);
      chk1("t3_progress", n_pops - p0 >= 2, 1'b1);

      // Redirect coinciding with a response and id_ready.
      lat_min = 1; lat_max = 1;
      idle(6);
      start_meas();
      step(1'b1, 32'h0000_0300);
      idle(8);
      meas = 1'b0;
      chk32("redir_first_req", 32'(first_req), 32'd1);
      chk32("redir_first_if", 32'(first_if), 32'd3);

      // Misaligned target faults; aligned target recovers.
      step(1'b1, 32'h0000_0102);
      idle(5);
      chk1("fault_held", fetch_fault, 1'b1);
      start_meas();
      step(1'b1, 32'h0000_0200);
      idle(8);
      meas = 1'b0;
      chk32("recover_first_req", 32'(first_req), 32'd1);
      chk32("recover_first_if", 32'(first_if), 32'd3);

      // PC wraps modulo 2^32.
      p0 = n_pops;
      step(1'b1, 32'hFFFF_FFF8);
      idle(8);
      chk1("wrap_progress", n_pops - p0 >= 4, 1'b1);

      // Reset with fetches in flight, then a late response.
      lat_min = 3; lat_max = 3;
      n = 0;
      while (mem_q.size() < 1 && n < 20) begin idle(1); n++; end
      lat_min = 1; lat_max = 1;
      do_reset(1'b1);
      start_meas();
      idle(10);
      meas = 1'b0;
      chk32("rst_mid_first_req", 32'(first_req), 32'd1);
      chk32("rst_mid_first_if", 32'(first_if), 32'd3);

      // Randomized traffic.
      p0 = n_pops;
      lat_min = 1; lat_max = 4; id_pct = 70; req_pct = 75;
      for (int i = 0; i < 3000; i++) begin
         redir = ($urandom_range(0, 99) < 3);
         rpc   = 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFC;
         if ($urandom_range(0, 6) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         step(redir, rpc);
      end
      chk1("random_progress", n_pops - p0 > 100, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
